aurora_axi_rx_pkt_fifo: RTL and testbench

// Store-and-forward packet FIFO directly downstream of the Aurora RX channel mux.
// The mux output has no backpressure, so this block absorbs it at line rate.
// A frame is released to the consumer only once its tlast word has been written.

---
 rtl/aurora_axi_rx_pkt_fifo_if.sv | 12 +
 rtl/aurora_axi_rx_pkt_fifo.sv | 116 +++++++++++
 tb/tb_aurora_axi_rx_pkt_fifo.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/aurora_axi_rx_pkt_fifo_if.sv
// AXI-stream style word bus used on both sides of the RX packet FIFO.
// Word = {tlast, tkeep[3:0], tdata[31:0]}.
interface aurora_axi_rx_pkt_fifo_if;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tvalid;
  logic        tlast;
  logic        tready;

  modport master (output tdata, tkeep, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/aurora_axi_rx_pkt_fifo.sv
// Store-and-forward packet FIFO behind the Aurora RX channel mux.
// The input cannot be stalled, so frames that do not fit are dropped whole;
// only frames whose tlast has been written are ever visible to the reader.
module aurora_axi_rx_pkt_fifo #(
  parameter int DEPTH_LOG2 = 9,
  parameter bit SIM        = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  aurora_axi_rx_pkt_fifo_if.slave       s_axis,
  aurora_axi_rx_pkt_fifo_if.master      m_axis,
  output logic [15:0]                   drop_cnt,
  output logic [15:0]                   frame_cnt,
  output logic                          drop_pulse
);
  localparam int DEPTH = 2**DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  typedef enum logic {PASS, DROP} wr_state_t;

  logic [36:0]   mem [DEPTH];
  wr_state_t     wr_state;
  logic [PW-1:0] wr_ptr, wr_commit, rd_ptr;
  logic          full, wr_en, have_data, load;
  logic          m_vld;
  logic [36:0]   m_word;

  // The mux has no backpressure; the sink side is always "ready".
  assign s_axis.tready = 1'b1;

  // Full is judged on registered pointers only, so a read this cycle
  // frees space from the next cycle onward.
  assign full      = (wr_ptr - rd_ptr) == DEPTH_P;
  assign wr_en     = (wr_state == PASS) && s_axis.tvalid && !full;
  assign have_data = rd_ptr != wr_commit;
  assign load      = have_data && (!m_vld || m_axis.tready);

  assign m_axis.tvalid = m_vld;
  assign {m_axis.tlast, m_axis.tkeep, m_axis.tdata} = m_word;

  // Packet RAM write port; contents are don't-care after reset.
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr[DEPTH_LOG2-1:0]] <= {s_axis.tlast, s_axis.tkeep, s_axis.tdata};

  // Write-side FSM: accept, commit on tlast, or rewind and drop the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state   <= PASS;
      wr_ptr     <= '0;
      wr_commit  <= '0;
      frame_cnt  <= '0;
      drop_cnt   <= '0;
      drop_pulse <= 1'b0;
    end else begin
      drop_pulse <= 1'b0;
      case (wr_state)
        PASS: begin
          if (s_axis.tvalid) begin
            if (!full) begin
              wr_ptr <= wr_ptr + 1'b1;
              if (s_axis.tlast) begin
                wr_commit <= wr_ptr + 1'b1;
                frame_cnt <= frame_cnt + 16'd1;
              end
            end else begin
              // Rewind discards the partial frame; space is reused only by later frames.
              wr_ptr <= wr_commit;
              if (s_axis.tlast) begin
                drop_cnt   <= (drop_cnt == 16'hFFFF) ? drop_cnt : drop_cnt + 16'd1;
                drop_pulse <= 1'b1;
              end else begin
                wr_state <= DROP;
              end
            end
          end
        end
        DROP: begin
          if (s_axis.tvalid && s_axis.tlast) begin
            drop_cnt   <= (drop_cnt == 16'hFFFF) ? drop_cnt : drop_cnt + 16'd1;
            drop_pulse <= 1'b1;
            wr_state   <= PASS;
          end
        end
        default: wr_state <= PASS;
      endcase
    end
  end

  // Registered output stage; the RAM read and the output register are the
  // same clock edge, and the stage holds while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_vld  <= 1'b0;
      m_word <= '0;
      rd_ptr <= '0;
    end else if (load) begin
      m_vld  <= 1'b1;
      m_word <= mem[rd_ptr[DEPTH_LOG2-1:0]];
      rd_ptr <= rd_ptr + 1'b1;
    end else if (m_axis.tready) begin
      m_vld  <= 1'b0;
    end
  end

  // Pointer ordering checks: rd_ptr <= wr_commit <= wr_ptr in modular terms.
  generate
    if (SIM) begin : g_sim
      always @(posedge clk)
        if (!rst) begin
          assert ((wr_ptr - wr_commit) <= DEPTH_P);
          assert ((wr_commit - rd_ptr) <= DEPTH_P);
        end
    end
  endgenerate
endmodule

// File: tb/tb_aurora_axi_rx_pkt_fifo.sv
// Directed bench for the RX packet FIFO at 16-word depth.
module tb_aurora_axi_rx_pkt_fifo;
  logic clk = 1'b0;
  logic rst;
  logic [15:0] drop_cnt, frame_cnt;
  logic drop_pulse;

  always #5 clk = ~clk;

  aurora_axi_rx_pkt_fifo_if s_axis ();
  aurora_axi_rx_pkt_fifo_if m_axis ();

  aurora_axi_rx_pkt_fifo #(.DEPTH_LOG2(4), .SIM(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_axis     (s_axis.slave),
    .m_axis     (m_axis.master),
    .drop_cnt   (drop_cnt),
    .frame_cnt  (frame_cnt),
    .drop_pulse (drop_pulse)
  );

  int checks = 0;
  int failures = 0;
  int pulses = 0;
  int stall_err = 0;
  logic [36:0] got[$];
  logic [36:0] exp_q[$];
  logic        stall_q = 1'b0;
  logic [36:0] held_q = '0;

  // Output monitor: captures accepted words, counts drop pulses, and flags
  // any change of the output while it is stalled.
  always @(negedge clk) begin
    logic [36:0] cur;
    cur = {m_axis.tlast, m_axis.tkeep, m_axis.tdata};
    if (rst) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q && (cur !== held_q || m_axis.tvalid !== 1'b1)) stall_err++;
      if (drop_pulse === 1'b1) pulses++;
      if (m_axis.tvalid === 1'b1 && m_axis.tready === 1'b1) got.push_back(cur);
      stall_q = (m_axis.tvalid === 1'b1) && (m_axis.tready === 1'b0);
      held_q  = cur;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic word(input logic [31:0] d, input logic [3:0] k, input logic l);
    s_axis.tvalid = 1'b1;
    s_axis.tdata  = d;
    s_axis.tkeep  = k;
    s_axis.tlast  = l;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
  endtask

  // Sends one frame; words of frames expected to survive go to exp_q.
  task automatic send_frame(input logic [31:0] base, input int n, input logic [3:0] last_keep,
                            input bit expect_pass);
    for (int i = 0; i < n; i++) begin
      logic [3:0] k;
      logic l;
      l = (i == n - 1);
      k = l ? last_keep : 4'hF;
      word(base + 32'(i), k, l);
      if (expect_pass) exp_q.push_back({l, k, base + 32'(i)});
    end
    idle();
  endtask

  task automatic cmp_q(input string tag);
    int n;
    n = exp_q.size();
    chk({tag, "_count"}, 64'(got.size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      logic [36:0] obs;
      obs = (i < got.size()) ? got[i] : 'x;
      chk($sformatf("%s_w%0d", tag, i), 64'(obs), 64'(exp_q[i]));
    end
    got.delete();
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1;
    s_axis.tvalid = 1'b0;
    s_axis.tdata  = '0;
    s_axis.tkeep  = '0;
    s_axis.tlast  = 1'b0;
    m_axis.tready = 1'b0;
    cyc(2);
    chk("rst_tvalid", 64'(m_axis.tvalid), 64'd0);
    chk("rst_tdata",  64'(m_axis.tdata),  64'd0);
    chk("rst_drop",   64'(drop_cnt),      64'd0);
    chk("rst_frame",  64'(frame_cnt),     64'd0);
    chk("rst_pulse",  64'(drop_pulse),    64'd0);
    rst = 1'b0;
    cyc(1);

    // 1: single 4-word frame, latency of tlast -> first valid is 2 cycles
    m_axis.tready = 1'b1;
    send_frame(32'hA0, 4, 4'hF, 1'b1);
    chk("t1_valid_n1", 64'(m_axis.tvalid), 64'd0);
    cyc(1);
    chk("t1_valid_n2", 64'(m_axis.tvalid), 64'd1);
    chk("t1_first",    64'(m_axis.tdata),  64'hA0);
    cyc(8);
    cmp_q("t1");
    chk("t1_frame_cnt", 64'(frame_cnt), 64'd1);

    // 2: three 5-word frames while stalled, then drain in order
    m_axis.tready = 1'b0;
    send_frame(32'h100, 5, 4'hF, 1'b1);
    send_frame(32'h200, 5, 4'h3, 1'b1);
    send_frame(32'h300, 5, 4'h1, 1'b1);
    cyc(3);
    chk("t2_drop_cnt",  64'(drop_cnt),      64'd0);
    chk("t2_frame_cnt", 64'(frame_cnt),     64'd4);
    chk("t2_hold_v",    64'(m_axis.tvalid), 64'd1);
    chk("t2_hold_d",    64'(m_axis.tdata),  64'h100);
    m_axis.tready = 1'b1;
    cyc(20);
    cmp_q("t2");

    // 3: 12-word frame fits, following 8-word frame overflows and drops
    m_axis.tready = 1'b0;
    pulses = 0;
    send_frame(32'h400, 12, 4'hF, 1'b1);
    send_frame(32'h500, 8,  4'hF, 1'b0);
    cyc(2);
    chk("t3_drop_cnt",  64'(drop_cnt),  64'd1);
    chk("t3_pulses",    64'(pulses),    64'd1);
    chk("t3_frame_cnt", 64'(frame_cnt), 64'd5);
    m_axis.tready = 1'b1;
    cyc(20);
    cmp_q("t3");
    chk("t3_empty", 64'(m_axis.tvalid), 64'd0);

    // 4: oversize frame drops, next frame (tkeep=0 on tlast) passes intact
    send_frame(32'h600, 20, 4'hF, 1'b0);
    send_frame(32'h700, 3,  4'h0, 1'b1);
    cyc(3);
    chk("t4_drop_cnt", 64'(drop_cnt), 64'd2);
    chk("t4_pulses",   64'(pulses),   64'd2);
    cyc(8);
    cmp_q("t4");
    chk("t4_frame_cnt", 64'(frame_cnt), 64'd6);

    // 5: tready toggling around a 6-word frame
    stall_err = 0;
    for (int i = 0; i < 6; i++) begin
      m_axis.tready = (i % 2 == 0);
      s_axis.tvalid = 1'b1;
      s_axis.tdata  = 32'h800 + 32'(i);
      s_axis.tkeep  = 4'hF;
      s_axis.tlast  = (i == 5);
      exp_q.push_back({(i == 5), 4'hF, 32'h800 + 32'(i)});
      cyc(1);
    end
    idle();
    for (int i = 0; i < 30; i++) begin
      m_axis.tready = (i % 2 == 0);
      cyc(1);
    end
    m_axis.tready = 1'b1;
    cyc(2);
    cmp_q("t5");
    chk("t5_stall_err",  64'(stall_err), 64'd0);
    chk("t5_frame_cnt",  64'(frame_cnt), 64'd7);

    // 6: reset in the middle of a frame with a word held on the output
    m_axis.tready = 1'b0;
    send_frame(32'h900, 2, 4'hF, 1'b1);
    cyc(3);
    chk("t6_pre_valid", 64'(m_axis.tvalid), 64'd1);
    word(32'hA00, 4'hF, 1'b0);
    word(32'hA01, 4'hF, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 64'(m_axis.tvalid), 64'd0);
    chk("t6_rst_data",  64'(m_axis.tdata),  64'd0);
    chk("t6_rst_keep",  64'(m_axis.tkeep),  64'd0);
    chk("t6_rst_last",  64'(m_axis.tlast),  64'd0);
    chk("t6_rst_drop",  64'(drop_cnt),      64'd0);
    chk("t6_rst_frame", 64'(frame_cnt),     64'd0);
    idle();
    got.delete();
    exp_q.delete();
    cyc(2);
    rst = 1'b0;
    cyc(1);
    m_axis.tready = 1'b1;
    send_frame(32'hB00, 3, 4'hF, 1'b1);
    cyc(8);
    cmp_q("t6");
    chk("t6_frame_cnt", 64'(frame_cnt), 64'd1);
    chk("t6_drop_cnt",  64'(drop_cnt),  64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
